// File: rtl/post_adder_acc_pkg.sv
// Shared constants for the DSP post-adder/accumulator: mux selects, opmode bit positions, widths.
package post_adder_acc_pkg;
    localparam int P_W = 48;
    localparam int M_W = 36;

    localparam logic [1:0] X_ZERO = 2'd0;
    localparam logic [1:0] X_M    = 2'd1;
    localparam logic [1:0] X_P    = 2'd2;
    localparam logic [1:0] X_DAB  = 2'd3;

    localparam logic [1:0] Z_ZERO = 2'd0;
    localparam logic [1:0] Z_PCIN = 2'd1;
    localparam logic [1:0] Z_P    = 2'd2;
    localparam logic [1:0] Z_C    = 2'd3;

    localparam int OP_CIN = 5;
    localparam int OP_SUB = 7;
endpackage

// File: rtl/post_adder_acc_pipe_reg.sv
// Generic enabled pipeline register, reset value 0, reset style chosen by RSTTYPE.
// Latency 1 cycle; ce=0 holds the value, reset overrides ce.
module post_adder_acc_pipe_reg #(
    parameter int    WIDTH   = 1,
    parameter string RSTTYPE = "SYNC"
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    generate
        if (RSTTYPE == "ASYNC") begin : g_async
            always_ff @(posedge clk or posedge rst) begin
                if (rst)     q <= '0;
                else if (ce) q <= d;
            end
        end else begin : g_sync
            always_ff @(posedge clk) begin
                if (rst)     q <= '0;
                else if (ce) q <= d;
            end
        end
    endgenerate
endmodule

// File: rtl/post_adder_acc.sv
// DSP48A1-style post-adder/accumulator: Z +/- (X + cin) into the P stage with carry-out.
// Latency 0 or 1 cycle per PREG/CARRYOUTREG; cep=0 freezes P and carryout (no backpressure).
module post_adder_acc
    import post_adder_acc_pkg::*;
#(
    parameter int    PREG        = 1,
    parameter int    CARRYINREG  = 1,
    parameter int    CARRYOUTREG = 1,
    parameter string CARRYINSEL  = "OPMODE5"
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cep,
    input  logic           cecarryin,
    input  logic [M_W-1:0] m,
    input  logic [P_W-1:0] c,
    input  logic [P_W-1:0] dab,
    input  logic [P_W-1:0] pcin,
    input  logic [7:0]     opmode,
    input  logic           carryin,
    output logic [P_W-1:0] p,
    output logic [P_W-1:0] pcout,
    output logic           carryout,
    output logic           carryoutf
);
    logic           cin_src;
    logic           cin_q;
    logic           cin;
    logic [P_W-1:0] p_q;
    logic           co_q;
    logic [P_W-1:0] x_mux;
    logic [P_W-1:0] z_mux;
    logic [P_W:0]   sum;
    logic           unused_bits;

    assign unused_bits = ^{opmode[6], opmode[5], opmode[4], carryin};

    generate
        if (CARRYINSEL == "OPMODE5") begin : g_cin_op
            assign cin_src = opmode[OP_CIN];
        end else if (CARRYINSEL == "CARRYIN") begin : g_cin_port
            assign cin_src = carryin;
        end else begin : g_cin_zero
            assign cin_src = 1'b0;
        end
    endgenerate

    post_adder_acc_pipe_reg #(.WIDTH(1), .RSTTYPE("SYNC")) u_cin_reg (
        .clk (clk),
        .rst (rst),
        .ce  (cecarryin),
        .d   (cin_src),
        .q   (cin_q)
    );

    assign cin = (CARRYINREG == 1) ? cin_q : cin_src;

    // Feedback always uses the P register so PREG=0 never closes a combinational loop.
    always_comb begin
        x_mux = '0;
        case (opmode[1:0])
            X_ZERO:  x_mux = '0;
            X_M:     x_mux = {{(P_W-M_W){1'b0}}, m};
            X_P:     x_mux = p_q;
            X_DAB:   x_mux = dab;
            default: x_mux = '0;
        endcase
        z_mux = '0;
        case (opmode[3:2])
            Z_ZERO:  z_mux = '0;
            Z_PCIN:  z_mux = pcin;
            Z_P:     z_mux = p_q;
            Z_C:     z_mux = c;
            default: z_mux = '0;
        endcase
        // Subtraction at 49 bits leaves the borrow in the top bit.
        if (opmode[OP_SUB])
            sum = {1'b0, z_mux} - ({1'b0, x_mux} + {{P_W{1'b0}}, cin});
        else
            sum = {1'b0, z_mux} + {1'b0, x_mux} + {{P_W{1'b0}}, cin};
    end

    post_adder_acc_pipe_reg #(.WIDTH(P_W), .RSTTYPE("SYNC")) u_p_reg (
        .clk (clk),
        .rst (rst),
        .ce  (cep),
        .d   (sum[P_W-1:0]),
        .q   (p_q)
    );

    post_adder_acc_pipe_reg #(.WIDTH(1), .RSTTYPE("SYNC")) u_co_reg (
        .clk (clk),
        .rst (rst),
        .ce  (cep),
        .d   (sum[P_W]),
        .q   (co_q)
    );

    assign p         = (PREG == 1) ? p_q : sum[P_W-1:0];
    assign pcout     = p;
    assign carryout  = (CARRYOUTREG == 1) ? co_q : sum[P_W];
    assign carryoutf = carryout;
endmodule

// File: tb/tb_post_adder_acc.sv
// Directed-vector bench: registered build (dut) plus fully combinational build (dut0) on shared stimulus.
module tb_post_adder_acc;
    logic        clk = 1'b0;
    logic        rst;
    logic        cep;
    logic        cecarryin;
    logic [35:0] m;
    logic [47:0] c;
    logic [47:0] dab;
    logic [47:0] pcin;
    logic [7:0]  opmode;
    logic        carryin;
    logic [47:0] p, pcout, p0, pcout0;
    logic        carryout, carryoutf, carryout0, carryoutf0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    post_adder_acc #(
        .PREG(1), .CARRYINREG(1), .CARRYOUTREG(1), .CARRYINSEL("OPMODE5")
    ) dut (
        .clk(clk), .rst(rst), .cep(cep), .cecarryin(cecarryin),
        .m(m), .c(c), .dab(dab), .pcin(pcin), .opmode(opmode), .carryin(carryin),
        .p(p), .pcout(pcout), .carryout(carryout), .carryoutf(carryoutf)
    );

    post_adder_acc #(
        .PREG(0), .CARRYINREG(0), .CARRYOUTREG(0), .CARRYINSEL("CARRYIN")
    ) dut0 (
        .clk(clk), .rst(rst), .cep(cep), .cecarryin(cecarryin),
        .m(m), .c(c), .dab(dab), .pcin(pcin), .opmode(opmode), .carryin(carryin),
        .p(p0), .pcout(pcout0), .carryout(carryout0), .carryoutf(carryoutf0)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; cep = 1'b1; cecarryin = 1'b1;
        m = 36'd7; c = 48'd9; dab = '0; pcin = '0;
        opmode = 8'h0D; carryin = 1'b0;

        // Reset with nonzero operands
        step();
        chk("rst_p", 64'(p), 64'd0);
        chk("rst_co", 64'(carryout), 64'd0);
        chk("rst_cof", 64'(carryoutf), 64'd0);
        step();
        cep = 1'b0;
        step();
        chk("rst_cep0_p", 64'(p), 64'd0);

        // Add: C + M
        rst = 1'b0; cep = 1'b1; opmode = 8'h0D; m = 36'd5; c = 48'd10;
        #1;
        chk("add_comb_p", 64'(p0), 64'd15);
        chk("add_pre_edge_p", 64'(p), 64'd0);
        step();
        chk("add_p", 64'(p), 64'd15);
        chk("add_co", 64'(carryout), 64'd0);

        // Accumulate: P + M
        rst = 1'b1;
        step();
        chk("acc_clr", 64'(p), 64'd0);
        rst = 1'b0; opmode = 8'h09; m = 36'd3;
        for (int i = 1; i <= 4; i++) begin
            step();
            chk($sformatf("acc_%0d", i), 64'(p), 64'(3 * i));
        end
        chk("acc_comb_fb", 64'(p0), 64'd15);
        cep = 1'b0;
        step();
        chk("acc_hold", 64'(p), 64'd12);
        chk("acc_hold_comb", 64'(p0), 64'd15);

        // Overflow wrap
        cep = 1'b1; opmode = 8'h0D; c = 48'hFFFF_FFFF_FFFF; m = 36'd1;
        #1;
        chk("ovf_comb_co", 64'(carryout0), 64'd1);
        chk("ovf_comb_p", 64'(p0), 64'd0);
        step();
        chk("ovf_p", 64'(p), 64'd0);
        chk("ovf_co", 64'(carryout), 64'd1);
        chk("ovf_cof", 64'(carryoutf), 64'd1);

        // Subtract with registered carry-in from opmode[5]
        opmode = 8'h2D; c = 48'd10; m = 36'd3;
        step();
        chk("cin_lag_p", 64'(p), 64'd13);
        opmode = 8'hAD;
        #1;
        chk("sub_comb_p", 64'(p0), 64'd7);
        step();
        chk("sub_p", 64'(p), 64'd6);
        chk("sub_co", 64'(carryout), 64'd0);
        c = 48'd2;
        #1;
        chk("borrow_comb_p", 64'(p0), 64'hFFFF_FFFF_FFFF);
        chk("borrow_comb_co", 64'(carryout0), 64'd1);
        step();
        chk("borrow_p", 64'(p), 64'hFFFF_FFFF_FFFE);
        chk("borrow_co", 64'(carryout), 64'd1);

        // Cascade: PCIN + DAB (registered cin still 1 for one edge)
        opmode = 8'h07; dab = 48'h0000_0001_0002; pcin = 48'h10;
        step();
        chk("casc_cin_lag", 64'(p), 64'h0000_0001_0013);
        step();
        chk("casc_p", 64'(p), 64'h0000_0001_0012);
        chk("casc_pcout", 64'(pcout), 64'h0000_0001_0012);
        chk("casc_comb_pcout", 64'(pcout0), 64'h0000_0001_0012);

        // Reset mid-accumulation, reset beats cep=0
        opmode = 8'h09; m = 36'd3;
        step();
        chk("mid_acc_p", 64'(p), 64'h0000_0001_0015);
        rst = 1'b1; cep = 1'b0;
        step();
        chk("mid_rst_p", 64'(p), 64'd0);
        chk("mid_rst_comb_p", 64'(p0), 64'd3);
        rst = 1'b0; cep = 1'b1;
        step();
        chk("restart_p", 64'(p), 64'd3);

        // Carry-in from the port on the combinational build
        opmode = 8'h0D; c = 48'd10; m = 36'd5; carryin = 1'b1;
        #1;
        chk("cin_port_comb_p", 64'(p0), 64'd16);
        step();
        chk("cin_port_ignored_p", 64'(p), 64'd15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
